fractal_sync_arbiter: RTL and testbench

FRACTAL_SYNC_ARBITER -- requirements
Module: fractal_sync_arbiter

---
 rtl/fractal_sync_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fractal_sync_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_sync_arbiter.sv
// Purpose: round-robin arbiter that lets N_REQ local requesters share one fractal sync-tree leaf port.
// Latency: req_i->sync_o 1 cycle, wake_i rise->ack_o 1 cycle, wake_i fall->done_o 1 cycle.
// Backpressure: one transaction at a time; other requests stay pending and are served in pointer order.
// Optional feature: define FRACTAL_SYNC_ARBITER_LVL_CHECK_EN to reject level-0 syncs locally with an error.
module fractal_sync_arbiter #(
  parameter int N_REQ     = 4,
  parameter int LVL_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*LVL_WIDTH-1:0] req_level_i,
  output logic [N_REQ-1:0]           done_o,
  output logic [N_REQ-1:0]           error_o,
  output logic                       busy_o,
  output logic                       sync_o,
  output logic [LVL_WIDTH-1:0]       level_o,
  output logic                       ack_o,
  input  logic                       wake_i,
  input  logic                       error_i
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [GW-1:0] LAST_IDX = GW'(N_REQ - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_WAKE = 3'd2,
    ACK       = 3'd3,
    WAIT_DROP = 3'd4,
    RESP      = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [LVL_WIDTH-1:0] level_q, level_d;
  logic                 err_q, err_d;

  // Arbitration candidates: first request at or above the pointer wins,
  // otherwise the first request below it (wrap-around).
  logic                 hi_found, lo_found;
  logic [GW-1:0]        hi_idx, lo_idx;
  logic [LVL_WIDTH-1:0] hi_lvl, lo_lvl;
  logic                 any_req;
  logic [GW-1:0]        pick_idx;
  logic [LVL_WIDTH-1:0] pick_lvl;

  // Round-robin pick starting at the pointer, split into an upper and a wrapped lower search.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_lvl   = '0;
    lo_lvl   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i]) begin
        if (GW'(i) >= ptr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = GW'(i);
            hi_lvl   = req_level_i[i*LVL_WIDTH +: LVL_WIDTH];
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = GW'(i);
          lo_lvl   = req_level_i[i*LVL_WIDTH +: LVL_WIDTH];
        end
      end
    end
    any_req  = hi_found | lo_found;
    pick_idx = hi_found ? hi_idx : lo_idx;
    pick_lvl = hi_found ? hi_lvl : lo_lvl;
  end

  // Next-state and Moore outputs; outputs depend only on state and latched registers.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    level_d = level_q;
    err_d   = err_q;
    done_o  = '0;
    error_o = '0;
    sync_o  = 1'b0;
    ack_o   = 1'b0;
    level_o = '0;
    busy_o  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick_idx;
          level_d = pick_lvl;
          err_d   = 1'b0;
`ifdef FRACTAL_SYNC_ARBITER_LVL_CHECK_EN
          // Level 0 is not a legal tree level: answer locally with an error.
          if (pick_lvl == '0) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        sync_o  = 1'b1;
        level_o = level_q;
        state_d = WAIT_WAKE;
      end
      WAIT_WAKE: begin
        level_o = level_q;
        if (wake_i) begin
          err_d   = error_i;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_o   = 1'b1;
        level_o = level_q;
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        level_o = level_q;
        if (!wake_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        done_o[grant_q]  = 1'b1;
        error_o[grant_q] = err_q;
        ptr_d            = (grant_q == LAST_IDX) ? '0 : grant_q + GW'(1);
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched transaction registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fractal_sync_arbiter.sv
// Bench for fractal_sync_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model (pending set, round-robin pointer, timeline of tree handshakes).
module tb_fractal_sync_arbiter;
  localparam int N  = 4;
  localparam int LW = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [N-1:0]  req_i;
  logic [N*LW-1:0] req_level_i;
  logic [N-1:0]  done_o, error_o;
  logic          busy_o, sync_o, ack_o;
  logic [LW-1:0] level_o;
  logic          wake_i, error_i;

  fractal_sync_arbiter #(.N_REQ(N), .LVL_WIDTH(LW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .req_level_i(req_level_i),
    .done_o(done_o), .error_o(error_o), .busy_o(busy_o), .sync_o(sync_o),
    .level_o(level_o), .ack_o(ack_o), .wake_i(wake_i), .error_i(error_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  int cur_g    = -1;
  bit arr_en   = 1'b0;
  int g_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [N-1:0] done_e, input logic [N-1:0] err_e,
                          input logic busy_e, input logic sync_e, input logic ack_e,
                          input logic [LW-1:0] lvl_e);
    chk({tag, ".done"},  32'(done_o),  32'(done_e));
    chk({tag, ".error"}, 32'(error_o), 32'(err_e));
    chk({tag, ".busy"},  32'(busy_o),  32'(busy_e));
    chk({tag, ".sync"},  32'(sync_o),  32'(sync_e));
    chk({tag, ".ack"},   32'(ack_o),   32'(ack_e));
    chk({tag, ".level"}, 32'(level_o), 32'(lvl_e));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic raise(input int i, input logic [LW-1:0] l);
    req_i[i] = 1'b1;
    req_level_i[i*LW +: LW] = l;
  endtask

  // Reference round-robin choice: first requester at pointer, pointer+1, ... (mod N).
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Random new requests from idle requesters (the one being served is excluded).
  task automatic arrive();
    if (arr_en) begin
      for (int i = 0; i < N; i++) begin
        if (!req_i[i] && i != cur_g && $urandom_range(0, 5) == 0)
          raise(i, LW'($urandom_range(0, (1 << LW) - 1)));
      end
    end
  endtask

  // Junk on the tree inputs while the arbiter must ignore them.
  task automatic noise();
    wake_i  = 1'($urandom_range(0, 1));
    error_i = 1'($urandom_range(0, 1));
  endtask

  // One full transaction starting from an observed IDLE cycle with req_i non-zero.
  // d: extra WAIT_WAKE cycles, h: extra cycles wake_i stays high after ack, e: tree error.
  task automatic run_txn(input int d, input int h, input bit e);
    int g;
    logic [LW-1:0] lv;
    logic [N-1:0]  oh;
    bit local_err;
    g     = rr_pick(req_i, ptr_m);
    lv    = req_level_i[g*LW +: LW];
    oh    = N'(1) << g;
    cur_g = g;
    g_last = g;
    local_err = 1'b0;
    noise();
    step();
`ifdef FRACTAL_SYNC_ARBITER_LVL_CHECK_EN
    if (lv == '0) local_err = 1'b1;
`endif
    if (!local_err) begin
      chk_outs("issue", '0, '0, 1'b1, 1'b1, 1'b0, lv);
      if (arr_en && $urandom_range(0, 3) == 0) req_i[g] = 1'b0;
      noise();
      arrive();
      step();
      chk_outs("wait_wake", '0, '0, 1'b1, 1'b0, 1'b0, lv);
      for (int k = 0; k < d; k++) begin
        wake_i  = 1'b0;
        error_i = 1'($urandom_range(0, 1));
        arrive();
        step();
        chk_outs("wait_wake_hold", '0, '0, 1'b1, 1'b0, 1'b0, lv);
      end
      wake_i  = 1'b1;
      error_i = e;
      arrive();
      step();
      chk_outs("ack", '0, '0, 1'b1, 1'b0, 1'b1, lv);
      noise();
      arrive();
      step();
      chk_outs("wait_drop", '0, '0, 1'b1, 1'b0, 1'b0, lv);
      for (int k = 0; k < h; k++) begin
        wake_i  = 1'b1;
        error_i = 1'($urandom_range(0, 1));
        arrive();
        step();
        chk_outs("wait_drop_stuck", '0, '0, 1'b1, 1'b0, 1'b0, lv);
      end
      wake_i  = 1'b0;
      error_i = 1'($urandom_range(0, 1));
      arrive();
      step();
    end
    chk_outs("resp", oh, (local_err || e) ? oh : '0, 1'b1, 1'b0, 1'b0, '0);
    req_i[g] = 1'b0;
    ptr_m    = (g + 1) % N;
    cur_g    = -1;
    noise();
    step();
    chk_outs("idle_after", '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rstn_i      = 1'b0;
    req_i       = '0;
    req_level_i = '0;
    wake_i      = 1'b0;
    error_i     = 1'b0;
    #1;
    chk_outs("reset", '0, '0, 1'b0, 1'b0, 1'b0, '0);
    step();
    step();
    rstn_i = 1'b1;
    step();
    chk_outs("post_reset_idle", '0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Single request, level 3, wake 5 cycles after sync.
    raise(0, 4'd3);
    run_txn(4, 0, 1'b0);

    // Tree error, then a clean transaction.
    raise(1, 4'd5);
    run_txn(1, 0, 1'b1);
    raise(2, 4'd7);
    run_txn(0, 0, 1'b0);

    // Stuck wake for 10 cycles after ack.
    raise(3, 4'd2);
    run_txn(0, 10, 1'b0);

    // Contention: all four held, pointer 0 -> 0,1,2,3,0.
    for (int i = 0; i < N; i++) raise(i, LW'(i + 1));
    for (int t = 0; t < 5; t++) begin
      run_txn(t % 3, t % 2, 1'b0);
      chk("contention.order", 32'(g_last), 32'(t % N));
      raise(g_last, LW'(g_last + 1));
    end
    req_i = '0;
    step();

    // Level 0 on requester 1.
    raise(1, 4'd0);
    run_txn(1, 0, 1'b0);

    // Reset while waiting for wake.
    raise(0, 4'd9);
    step();
    chk_outs("pre_reset_issue", '0, '0, 1'b1, 1'b1, 1'b0, 4'd9);
    step();
    chk_outs("pre_reset_wait", '0, '0, 1'b1, 1'b0, 1'b0, 4'd9);
    rstn_i = 1'b0;
    #1;
    chk_outs("async_reset", '0, '0, 1'b0, 1'b0, 1'b0, '0);
    req_i = '0;
    step();
    chk_outs("in_reset", '0, '0, 1'b0, 1'b0, 1'b0, '0);
    rstn_i = 1'b1;
    ptr_m  = 0;
    raise(2, 4'd4);
    run_txn(2, 1, 1'b0);
    chk("reset.grant", 32'(g_last), 32'd2);

    // Randomized traffic.
    arr_en = 1'b1;
    for (int it = 0; it < 200; it++) begin
      if (req_i == '0) begin
        noise();
        arrive();
        if (req_i == '0) begin
          step();
          chk_outs("rand_idle", '0, '0, 1'b0, 1'b0, 1'b0, '0);
        end
      end else begin
        run_txn($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
